sar_switch_ctrl: RTL and testbench

//   Digital SAR controller driving the DAC switch-matrix selects {o_Sprg,o_Ssmpl}.

---
 rtl/sar_pkg.sv | 18 +
 rtl/sar_reg.sv | 62 ++++++
 rtl/sar_switch_ctrl.sv | 117 +++++++++++
 tb/tb_sar_switch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and switch-matrix encodings for the SAR switch controller.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        PRECH,
        CONV,
        DONE
    } sar_state_e;

    // Switch-matrix select encodings, {Sprg, Ssmpl}
    localparam logic [1:0] SW_MAT  = 2'b00;
    localparam logic [1:0] SW_VIN  = 2'b01;
    localparam logic [1:0] SW_VREF = 2'b10;
    localparam logic [1:0] SW_MID  = 2'b11;

endpackage

// File: rtl/sar_reg.sv
// Successive-approximation register: holds the partial result, the current
// trial code and the bit index being resolved (MSB first).
module sar_reg
    import sar_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_step,
    input  logic              i_cmp,
    output logic [N_BITS-1:0] o_trial,
    output logic [N_BITS-1:0] o_result,
    output logic              o_last
);

    localparam int IDX_W = $clog2(N_BITS);
    localparam logic [N_BITS-1:0] ONE = N_BITS'(1);

    logic [N_BITS-1:0] result_q, result_d;
    logic [N_BITS-1:0] trial_q,  trial_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        result_d = result_q;
        trial_d  = trial_q;
        idx_d    = idx_q;
        if (i_clr) begin
            result_d = '0;
            idx_d    = IDX_W'(N_BITS - 1);
            trial_d  = ONE << (N_BITS - 1);
        end else if (i_step) begin
            result_d[idx_q] = i_cmp;
            if (idx_q != '0) begin
                idx_d   = idx_q - 1'b1;
                trial_d = result_d | (ONE << (idx_q - 1'b1));
            end else begin
                trial_d = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments and an async active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
            trial_q  <= '0;
            idx_q    <= '0;
        end else begin
            result_q <= result_d;
            trial_q  <= trial_d;
            idx_q    <= idx_d;
        end
    end

    assign o_trial  = trial_q;
    assign o_result = result_q;
    assign o_last   = (idx_q == '0);

endmodule

// File: rtl/sar_switch_ctrl.sv
// SAR conversion controller: sequences the DAC switch matrix, runs the binary
// search against the comparator and drives the real-valued matrix DAC voltage.
module sar_switch_ctrl
    import sar_pkg::*;
#(
    parameter int N_BITS   = 8,
    parameter int SMPL_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_cmp,
    input  real               i_Vref_L,
    output logic              o_Sprg,
    output logic              o_Ssmpl,
    output real               o_Vdac_mat,
    output logic              o_busy,
    output logic              o_valid,
    output logic [N_BITS-1:0] o_data
);

    localparam int CNT_W = $clog2(SMPL_CYC + 1);

    sar_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        sw_q;
    logic              busy_q;
    logic              valid_q;
    logic [N_BITS-1:0] data_q;

    logic              sar_clr;
    logic              sar_step;
    logic              sar_last;
    logic [N_BITS-1:0] trial;
    logic [N_BITS-1:0] result;

    assign sar_clr  = (state_q == PRECH);
    assign sar_step = (state_q == CONV);

    sar_reg #(.N_BITS(N_BITS)) u_sar_reg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (sar_clr),
        .i_step   (sar_step),
        .i_cmp    (i_cmp),
        .o_trial  (trial),
        .o_result (result),
        .o_last   (sar_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sw_q    <= SW_MAT;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= SAMPLE;
                        cnt_q   <= '0;
                        sw_q    <= SW_VIN;
                        busy_q  <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt_q != CNT_W'(SMPL_CYC)) cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SMPL_CYC - 1)) begin
                        state_q <= PRECH;
                        sw_q    <= SW_VREF;
                    end
                end
                PRECH: begin
                    state_q <= CONV;
                    sw_q    <= SW_MAT;
                end
                CONV: begin
                    // The LSB decision lands in the result register on this same
                    // edge, so merge it here to publish data together with valid.
                    if (sar_last) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        data_q  <= result | N_BITS'(i_cmp);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    sw_q    <= SW_MAT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_Vdac_mat = 0.0;
        if (state_q == CONV) o_Vdac_mat = i_Vref_L * real'(trial) / (2.0 ** N_BITS);
    end

    assign o_Sprg  = sw_q[1];
    assign o_Ssmpl = sw_q[0];
    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;

    a_no_mid_switch: assert property (@(posedge i_clk) disable iff (!i_rst_n) sw_q != SW_MID);
    a_valid_busy:    assert property (@(posedge i_clk) disable iff (!i_rst_n) valid_q |-> busy_q);

endmodule

// File: tb/tb_sar_switch_ctrl.sv
// Directed bench for sar_switch_ctrl with an ideal comparator model closing the loop.
module tb_sar_switch_ctrl;

    localparam int  N_BITS   = 8;
    localparam int  SMPL_CYC = 4;
    localparam real VREF     = 1.0;
    localparam int  LATENCY  = SMPL_CYC + 1 + N_BITS + 1;
    localparam int  MAX_CYC  = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cmp;
    real  vref = VREF;
    real  vin = 0.0;
    logic sprg, ssmpl;
    real  vdac;
    logic busy, valid;
    logic [N_BITS-1:0] data;
    logic [1:0] sw;

    int checks = 0;
    int failures = 0;

    logic [1:0] sw_log [1:MAX_CYC];
    real        v_log  [1:MAX_CYC];

    always #5 clk = ~clk;

    assign sw  = {sprg, ssmpl};
    assign cmp = (vin >= vdac);

    sar_switch_ctrl #(.N_BITS(N_BITS), .SMPL_CYC(SMPL_CYC)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_cmp      (cmp),
        .i_Vref_L   (vref),
        .o_Sprg     (sprg),
        .o_Ssmpl    (ssmpl),
        .o_Vdac_mat (vdac),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_data     (data)
    );

    // Accepts a start in IDLE, then samples outputs at each negedge; cycle c is
    // the c-th clock period after the accepting edge. Returns when o_valid seen.
    task automatic run_conversion(input real v, input logic [N_BITS-1:0] exp_code, input string tag);
        int  vcyc;
        bit  range_bad;
        real bad_v;
        vin = v;
        vcyc = 0;
        range_bad = 1'b0;
        bad_v = 0.0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= MAX_CYC && vcyc == 0; c++) begin
            @(negedge clk);
            sw_log[c] = sw;
            v_log[c]  = vdac;
            if (vdac < 0.0 || vdac >= VREF) begin
                range_bad = 1'b1;
                bad_v = vdac;
            end
            if (valid) begin
                vcyc = c;
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy_at_valid got=%b exp=1", tag, busy);
                end
                checks++;
                if (data !== exp_code) begin
                    failures++;
                    $display("FAIL %s data got=%h exp=%h", tag, data, exp_code);
                end
            end
        end
        checks++;
        if (vcyc != LATENCY) begin
            failures++;
            $display("FAIL %s valid_cycle got=%0d exp=%0d", tag, vcyc, LATENCY);
        end
        checks++;
        if (range_bad) begin
            failures++;
            $display("FAIL %s vdac_range got=%f exp=[0,%f)", tag, bad_v, VREF);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sw !== 2'b00) begin failures++; $display("FAIL reset sw got=%b exp=00", sw); end
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset busy_valid got=%b%b exp=00", busy, valid);
        end
        checks++;
        if (data !== '0) begin failures++; $display("FAIL reset data got=%h exp=00", data); end
        checks++;
        if (vdac != 0.0) begin failures++; $display("FAIL reset vdac got=%f exp=0.0", vdac); end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_midscale();
        logic [1:0] exp_sw;
        int bad_c;
        run_conversion(0.5, 8'h80, "mid");
        bad_c = 0;
        for (int c = 1; c <= LATENCY - 1; c++) begin
            exp_sw = (c <= SMPL_CYC) ? 2'b01 : (c == SMPL_CYC + 1) ? 2'b10 : 2'b00;
            if (sw_log[c] !== exp_sw && bad_c == 0) bad_c = c;
        end
        checks++;
        if (bad_c != 0) begin
            failures++;
            $display("FAIL mid sw_seq cycle=%0d got=%b exp=%b", bad_c, sw_log[bad_c],
                     (bad_c <= SMPL_CYC) ? 2'b01 : (bad_c == SMPL_CYC + 1) ? 2'b10 : 2'b00);
        end
    endtask

    task automatic test_trials();
        real exp_v [5];
        exp_v = '{0.5, 0.25, 0.375, 0.3125, 0.28125};
        run_conversion(0.3, 8'h4C, "v0p3");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (v_log[SMPL_CYC + 2 + i] != exp_v[i]) begin
                failures++;
                $display("FAIL v0p3 trial%0d got=%f exp=%f", i, v_log[SMPL_CYC + 2 + i], exp_v[i]);
            end
        end
    endtask

    // Second start is driven in the first IDLE cycle after DONE.
    task automatic test_back_to_back();
        run_conversion(0.0, 8'h00, "zero");
        run_conversion(0.999, 8'hFF, "full");
    endtask

    task automatic test_ignored_start();
        logic [N_BITS-1:0] prev;
        int  nvalid;
        int  vcyc;
        bit  held_bad;
        prev = data;
        nvalid = 0;
        vcyc = 0;
        held_bad = 1'b0;
        vin = 0.3;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= MAX_CYC; c++) begin
            @(negedge clk);
            if (valid) begin
                nvalid++;
                vcyc = c;
            end
            if ((nvalid == 0 && data !== prev) || (nvalid > 0 && data !== 8'h4C)) held_bad = 1'b1;
            start = (c == 2 || c == 8 || c == LATENCY);
        end
        start = 1'b0;
        checks++;
        if (nvalid != 1) begin failures++; $display("FAIL ign valid_count got=%0d exp=1", nvalid); end
        checks++;
        if (vcyc != LATENCY) begin
            failures++;
            $display("FAIL ign valid_cycle got=%0d exp=%0d", vcyc, LATENCY);
        end
        checks++;
        if (held_bad) begin failures++; $display("FAIL ign data_hold got=%h exp=%h", data, 8'h4C); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ign busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_conv();
        vin = 0.5;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (SMPL_CYC + 1 + (N_BITS - 4)) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || sw !== 2'b00) begin
            failures++;
            $display("FAIL rstmid pre busy_sw got=%b_%b exp=1_00", busy, sw);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sw !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid busy_sw got=%b_%b exp=0_00", busy, sw);
        end
        checks++;
        if (data !== '0) begin failures++; $display("FAIL rstmid data got=%h exp=00", data); end
        checks++;
        if (vdac != 0.0) begin failures++; $display("FAIL rstmid vdac got=%f exp=0.0", vdac); end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_conversion(0.5, 8'h80, "post_rst");
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_trials();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_conv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
